// File: rtl/mux_stream_n.sv
// mux_stream_n: N-channel stream multiplexer with a registered output stage.
//
// Picks one of CH valid/ready input channels and loads its word into a single
// output register with a valid/ready handshake toward the consumer. MODE 0
// selects the channel explicitly through i_s. MODE 1 arbitrates round-robin,
// starting the scan one past the last granted channel.
//
// Ports:
//   i_clk    in   1     clock, rising edge
//   i_rst    in   1     synchronous active-high reset
//   i_D      in   CH*n  flattened channel data, channel k at [k*n +: n]
//   i_valid  in   CH    per-channel valid
//   o_ready  out  CH    per-channel accept strobe (combinational)
//   i_s      in   SW    channel select, MODE 0 only
//   o_Y      out  n     registered output data
//   o_valid  out  1     registered output valid
//   i_ready  in   1     downstream ready
//   o_ch     out  SW    channel index of the word in o_Y
module mux_stream_n #(
    parameter int unsigned n    = 32,
    parameter int unsigned CH   = 4,
    parameter int unsigned MODE = 0,
    localparam int unsigned SW  = $clog2(CH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [CH*n-1:0] i_D,
    input  logic [CH-1:0] i_valid,
    output logic [CH-1:0] o_ready,
    input  logic [SW-1:0] i_s,
    output logic [n-1:0]  o_Y,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [SW-1:0] o_ch
);

    logic [CH-1:0] g;
    logic [SW-1:0] g_idx;
    logic          g_any;
    logic [SW-1:0] scan;
    logic          ld;
    logic [n-1:0]  sel_data;

    logic [n-1:0]  y_q;
    logic          valid_q;
    logic [SW-1:0] ch_q;
    logic [SW-1:0] ptr_q;

    // Output register may take a new word when empty or draining this edge.
    assign ld = !valid_q || i_ready;

    always_comb begin
        g     = '0;
        g_idx = '0;
        g_any = 1'b0;
        scan  = '0;
        if (MODE == 0) begin
            // Out-of-range select simply grants nothing.
            if (32'(i_s) < CH) begin
                if (i_valid[i_s]) begin
                    g[i_s] = 1'b1;
                    g_idx  = i_s;
                    g_any  = 1'b1;
                end
            end
        end else begin
            // Scan ptr+1 .. ptr+CH (mod CH); first valid channel wins.
            for (int unsigned off = 1; off <= CH; off++) begin
                scan = SW'((32'(ptr_q) + off) % CH);
                if (!g_any && i_valid[scan]) begin
                    g[scan] = 1'b1;
                    g_idx   = scan;
                    g_any   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_ready = '0;
        if (!i_rst) begin
            o_ready = g & {CH{ld}};
        end
    end

    assign sel_data = i_D[32'(g_idx) * n +: n];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= SW'(CH - 1);
        end else if (ld) begin
            if (g_any) begin
                y_q     <= sel_data;
                ch_q    <= g_idx;
                valid_q <= 1'b1;
                if (MODE != 0) begin
                    ptr_q <= g_idx;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_Y     = y_q;
    assign o_valid = valid_q;
    assign o_ch    = ch_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// tb_mux_stream_n: scoreboard bench for mux_stream_n.
//
// Three instances run side by side: u0 (CH=4, select), u1 (CH=4, round-robin)
// and u2 (CH=3, select). Stimulus pushes the hand-computed {ch, data} of each
// word it expects to be accepted; per-instance monitors pop and compare
// whenever an output word is consumed (o_valid && i_ready).
module tb_mux_stream_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: CH=4 MODE=0
    logic        rst0;
    logic [31:0] d0;
    logic [3:0]  v0, r0;
    logic [1:0]  s0, ch0;
    logic [7:0]  y0;
    logic        ov0, ir0;
    // u1: CH=4 MODE=1
    logic        rst1;
    logic [31:0] d1;
    logic [3:0]  v1, r1;
    logic [1:0]  s1, ch1;
    logic [7:0]  y1;
    logic        ov1, ir1;
    // u2: CH=3 MODE=0
    logic        rst2;
    logic [23:0] d2;
    logic [2:0]  v2, r2;
    logic [1:0]  s2, ch2;
    logic [7:0]  y2;
    logic        ov2, ir2;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic [9:0] e0, e1, e2;

    mux_stream_n #(.n(8), .CH(4), .MODE(0)) u0 (
        .i_clk(clk), .i_rst(rst0), .i_D(d0), .i_valid(v0), .o_ready(r0), .i_s(s0),
        .o_Y(y0), .o_valid(ov0), .i_ready(ir0), .o_ch(ch0)
    );
    mux_stream_n #(.n(8), .CH(4), .MODE(1)) u1 (
        .i_clk(clk), .i_rst(rst1), .i_D(d1), .i_valid(v1), .o_ready(r1), .i_s(s1),
        .o_Y(y1), .o_valid(ov1), .i_ready(ir1), .o_ch(ch1)
    );
    mux_stream_n #(.n(8), .CH(3), .MODE(0)) u2 (
        .i_clk(clk), .i_rst(rst2), .i_D(d2), .i_valid(v2), .o_ready(r2), .i_s(s2),
        .o_Y(y2), .o_valid(ov2), .i_ready(ir2), .o_ch(ch2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output word with empty scoreboard (t=%0t)", name, $time);
    endtask

    task automatic tick(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input int k);
        logic [31:0] tbl;
        tbl = 32'h44332211;
        return tbl[k*8 +: 8];
    endfunction

    // Monitors: one word consumed per cycle where o_valid && i_ready.
    always @(negedge clk) begin
        if (ov0 && ir0) begin
            if (q0.size() == 0) fail_now("u0_unexpected");
            else begin
                e0 = q0.pop_front();
                chk("u0_word", {22'd0, ch0, y0}, {22'd0, e0});
            end
        end
        if (ov1 && ir1) begin
            if (q1.size() == 0) fail_now("u1_unexpected");
            else begin
                e1 = q1.pop_front();
                chk("u1_word", {22'd0, ch1, y1}, {22'd0, e1});
            end
        end
        if (ov2 && ir2) begin
            if (q2.size() == 0) fail_now("u2_unexpected");
            else begin
                e2 = q2.pop_front();
                chk("u2_word", {22'd0, ch2, y2}, {22'd0, e2});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; d0 = 32'h44332211; v0 = 4'hf; ir0 = 1'b1; s0 = 2'd2;
        rst1 = 1'b1; d1 = 32'h44332211; v1 = 4'hf; ir1 = 1'b1; s1 = 2'd0;
        rst2 = 1'b1; d2 = 24'h332211;   v2 = 3'h7; ir2 = 1'b1; s2 = 2'd1;

        fork
            // ---------------- u1: reset, round-robin, mid-stream reset ----
            begin
                logic [1:0] alt[4];
                alt = '{2'd3, 2'd1, 2'd3, 2'd1};
                for (int c = 0; c < 2; c++) begin
                    tick(1);
                    chk("rst_valid", 32'(ov1), 32'd0);
                    chk("rst_y", 32'(y1), 32'd0);
                    chk("rst_ch", 32'(ch1), 32'd0);
                    chk("rst_ready", 32'(r1), 32'd0);
                end
                rst1 = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    #1 chk("rr_ready", 32'(r1), 32'(4'b0001 << (i % 4)));
                    q1.push_back({2'(i % 4), byte_of(i % 4)});
                    tick(1);
                end
                v1 = 4'b0100;
                for (int i = 0; i < 4; i++) begin
                    #1 chk("single_ready", 32'(r1), 32'h4);
                    q1.push_back({2'd2, 8'h33});
                    tick(1);
                end
                v1 = 4'b1010;
                for (int i = 0; i < 4; i++) begin
                    #1 chk("alt_ready", 32'(r1), 32'(4'b0001 << alt[i]));
                    q1.push_back({alt[i], byte_of(int'(alt[i]))});
                    tick(1);
                end
                v1 = 4'b0000;
                tick(1);
                chk("rr_drain_valid", 32'(ov1), 32'd0);
                tick(1);
                chk("rr_idle_valid", 32'(ov1), 32'd0);
                // Last grant was channel 1, so all-valid resumes at channel 2.
                v1 = 4'b1111;
                #1 chk("ptr_hold_ready", 32'(r1), 32'h4);
                q1.push_back({2'd2, 8'h33});
                tick(1);
                ir1 = 1'b0;
                #1 chk("stall_ready", 32'(r1), 32'd0);
                tick(1);
                chk("stall_ch", 32'(ch1), 32'd2);
                chk("stall_valid", 32'(ov1), 32'd1);
                rst1 = 1'b1;
                tick(1);
                chk("midrst_valid", 32'(ov1), 32'd0);
                chk("midrst_dropped", 32'(q1.size()), 32'd1);
                q1.delete();
                rst1 = 1'b0;
                ir1 = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    #1 chk("post_rst_ready", 32'(r1), 32'(4'b0001 << i));
                    q1.push_back({2'(i), byte_of(i)});
                    tick(1);
                end
                v1 = 4'b0000;
                tick(2);
            end
            // ---------------- u0: select, backpressure ----------------------
            begin
                tick(1);
                chk("u0_rst_ready", 32'(r0), 32'd0);
                tick(1);
                rst0 = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1 chk("sel2_ready", 32'(r0), 32'h4);
                    q0.push_back({2'd2, 8'h33});
                    tick(1);
                end
                s0 = 2'd3;
                #1 chk("sel3_ready", 32'(r0), 32'h8);
                q0.push_back({2'd3, 8'h44});
                tick(1);
                s0 = 2'd2;
                q0.push_back({2'd2, 8'h33});
                tick(1);
                ir0 = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    s0 = 2'(i);
                    d0 = {8'hc4, 8'hc3, 8'hc2, 8'hc1} ^ {4{8'(i)}};
                    #1 chk("bp_ready", 32'(r0), 32'd0);
                    tick(1);
                    chk("bp_y", 32'(y0), 32'h33);
                    chk("bp_ch", 32'(ch0), 32'd2);
                    chk("bp_valid", 32'(ov0), 32'd1);
                end
                d0 = 32'h9d5a7e01;
                s0 = 2'd1;
                ir0 = 1'b1;
                #1 chk("release_ready", 32'(r0), 32'h2);
                q0.push_back({2'd1, 8'h7e});
                tick(1);
                chk("nobubble_y", 32'(y0), 32'h7e);
                chk("nobubble_valid", 32'(ov0), 32'd1);
                v0 = 4'b0000;
                tick(1);
                chk("u0_idle_valid", 32'(ov0), 32'd0);
            end
            // ---------------- u2: CH=3, out-of-range select ------------------
            begin
                tick(2);
                rst2 = 1'b0;
                #1 chk("u2_sel1_ready", 32'(r2), 32'h2);
                q2.push_back({2'd1, 8'h22});
                tick(1);
                s2 = 2'd3;
                #1 chk("oor_ready", 32'(r2), 32'd0);
                tick(1);
                chk("oor_drain_valid", 32'(ov2), 32'd0);
                chk("oor_ready2", 32'(r2), 32'd0);
                tick(1);
                chk("oor_idle_valid", 32'(ov2), 32'd0);
                s2 = 2'd0;
                v2 = 3'b000;
                #1 chk("u2_novalid_ready", 32'(r2), 32'd0);
                tick(1);
                chk("u2_novalid_valid", 32'(ov2), 32'd0);
            end
        join

        tick(3);
        chk("u0_sb_empty", 32'(q0.size()), 32'd0);
        chk("u1_sb_empty", 32'(q1.size()), 32'd0);
        chk("u2_sb_empty", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
